gpio_ctrl: RTL and testbench

Parametrised bus-attached GPIO controller for 1..32 pins. It provides per-pin output data, output enable, synchronised input readback, atomic set/clear, and per-pin rising/falling edge interrupts.
- Pads are split into separate in, out and output-enable signals; the tristate buffer sits in the pad ring.
- The block is a peripheral slave on the standard req/rvalid bus, alongside the other memory-mapped peripherals.

---
 rtl/gpio_ctrl.sv | 168 ++++++++++++++++
 tb/tb_gpio_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// ============================================================================
// gpio_ctrl : bus-attached GPIO controller with synchronised inputs, atomic
//             set/clear and per-pin edge interrupts. Optional: GPIO_DEBOUNCE_EN
// Revision  : 1.0
// ============================================================================
`default_nettype none

module gpio_ctrl #(
  parameter int unsigned NumPins        = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumPins-1:0]        gpio_i,
  output logic [NumPins-1:0]        gpio_o,
  output logic [NumPins-1:0]        gpio_oe_o,
  input  logic                      gpio_req_i,
  input  logic [AddressWidth-1:0]   gpio_addr_i,
  input  logic                      gpio_we_i,
  input  logic [DataWidth/8-1:0]    gpio_be_i,
  input  logic [DataWidth-1:0]      gpio_wdata_i,
  output logic                      gpio_rvalid_o,
  output logic [DataWidth-1:0]      gpio_rdata_o,
  output logic                      gpio_err_o,
  output logic                      gpio_intr_o
);

  localparam logic [2:0] RegDataOut = 3'd0;
  localparam logic [2:0] RegOutEn   = 3'd1;
  localparam logic [2:0] RegDataIn  = 3'd2;
  localparam logic [2:0] RegSet     = 3'd3;
  localparam logic [2:0] RegClr     = 3'd4;
  localparam logic [2:0] RegRiseEn  = 3'd5;
  localparam logic [2:0] RegFallEn  = 3'd6;
  localparam logic [2:0] RegIntr    = 3'd7;

  logic [NumPins-1:0] data_out_q, data_out_d;
  logic [NumPins-1:0] out_en_q, out_en_d;
  logic [NumPins-1:0] rise_en_q, rise_en_d;
  logic [NumPins-1:0] fall_en_q, fall_en_d;
  logic [NumPins-1:0] intr_q, intr_d;
  logic [NumPins-1:0] in_prev_q;
  logic [NumPins-1:0] sync_q [SyncStages];
  logic               rvalid_q, err_q, err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic [2:0]           reg_sel;
  logic                 req_err, wr_en;
  logic [DataWidth-1:0] be_mask;
  logic [NumPins-1:0]   wmask, wbits, in_val, in_sync, events;
  logic                 unused_bits;

  assign reg_sel = gpio_addr_i[4:2];
  assign req_err = (|gpio_addr_i[1:0]) | (gpio_we_i & (reg_sel == RegDataIn));
  assign wr_en   = gpio_req_i & gpio_we_i & ~req_err;
  assign unused_bits = ^{gpio_addr_i, gpio_wdata_i};

  for (genvar b = 0; b < DataWidth / 8; b++) begin : g_be
    assign be_mask[b*8 +: 8] = {8{gpio_be_i[b]}};
  end

  assign wmask   = be_mask[NumPins-1:0];
  assign wbits   = gpio_wdata_i[NumPins-1:0] & wmask;
  assign in_sync = sync_q[SyncStages-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  // A pin's debounced value moves only after a run of DebounceCycles disagreeing samples.
  for (genvar p = 0; p < NumPins; p++) begin : g_deb
    logic [CntW-1:0] cnt_q;
    logic            deb_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (in_sync[p] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DebounceCycles - 1)) begin
        cnt_q <= '0;
        deb_q <= in_sync[p];
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
    assign in_val[p] = deb_q;
  end
`else
  assign in_val = in_sync;
`endif

  assign events = (in_val & ~in_prev_q & rise_en_q) | (~in_val & in_prev_q & fall_en_q);

  always_comb begin
    data_out_d = data_out_q;
    out_en_d   = out_en_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    intr_d     = intr_q;
    rdata_d    = '0;
    err_d      = gpio_req_i & req_err;
    if (wr_en) begin
      unique case (reg_sel)
        RegDataOut: data_out_d = (data_out_q & ~wmask) | wbits;
        RegOutEn:   out_en_d   = (out_en_q & ~wmask) | wbits;
        RegSet:     data_out_d = data_out_q | wbits;
        RegClr:     data_out_d = data_out_q & ~wbits;
        RegRiseEn:  rise_en_d  = (rise_en_q & ~wmask) | wbits;
        RegFallEn:  fall_en_d  = (fall_en_q & ~wmask) | wbits;
        RegIntr:    intr_d     = intr_q & ~wbits;
        default:    ;
      endcase
    end
    // New events are merged after the clear so a coincident event keeps its bit.
    intr_d = intr_d | events;
    if (gpio_req_i && !gpio_we_i && !req_err) begin
      unique case (reg_sel)
        RegDataOut: rdata_d = DataWidth'(data_out_q);
        RegOutEn:   rdata_d = DataWidth'(out_en_q);
        RegDataIn:  rdata_d = DataWidth'(in_val);
        RegRiseEn:  rdata_d = DataWidth'(rise_en_q);
        RegFallEn:  rdata_d = DataWidth'(fall_en_q);
        RegIntr:    rdata_d = DataWidth'(intr_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
      in_prev_q  <= '0;
      data_out_q <= '0;
      out_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      intr_q     <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
      in_prev_q  <= in_val;
      data_out_q <= data_out_d;
      out_en_q   <= out_en_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      intr_q     <= intr_d;
      rvalid_q   <= gpio_req_i;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign gpio_o        = data_out_q;
  assign gpio_oe_o     = out_en_q;
  assign gpio_rvalid_o = rvalid_q;
  assign gpio_rdata_o  = rdata_q;
  assign gpio_err_o    = err_q;
  assign gpio_intr_o   = |intr_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
// ============================================================================
// tb_gpio_ctrl : directed self-checking bench for gpio_ctrl
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_gpio_ctrl;

`ifdef GPIO_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out, gpio_oe;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid, err, intr;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic        rv, er;
  logic [31:0] rd;

  always #5 clk = ~clk;

  gpio_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_oe_o(gpio_oe),
    .gpio_req_i(req), .gpio_addr_i(addr), .gpio_we_i(we), .gpio_be_i(be), .gpio_wdata_i(wdata),
    .gpio_rvalid_o(rvalid), .gpio_rdata_o(rdata), .gpio_err_o(err), .gpio_intr_o(intr)
  );

  // Called 1ns after a rising edge; returns the response sampled 1ns after the next edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                     output logic o_rv, output logic [31:0] o_rd, output logic o_er);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; be = '0; wdata = '0;
    o_rv = rvalid; o_rd = rdata; o_er = err;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL rst_gpio_o got %h exp 0", gpio_out); end
    checks++; if (gpio_oe !== 32'h0) begin errors++; $display("FAIL rst_gpio_oe got %h exp 0", gpio_oe); end
    checks++; if ({rvalid, err, intr} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {rvalid, err, intr}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    bus(0, 32'h1C, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_intr_state got %h exp 0", rd); end
  endtask

  task automatic test_output;
    bus(1, 32'h04, 4'hF, 32'hFFFF_FFFF, rv, rd, er);
    bus(1, 32'h00, 4'hF, 32'hA5A5_0F0F, rv, rd, er);
    checks++; if (gpio_oe !== 32'hFFFF_FFFF) begin errors++; $display("FAIL out_oe got %h exp ffffffff", gpio_oe); end
    checks++; if (gpio_out !== 32'hA5A5_0F0F) begin errors++; $display("FAIL out_data got %h exp a5a50f0f", gpio_out); end
    bus(0, 32'h00, 4'hF, 0, rv, rd, er);
    checks++; if ({rv, er} !== 2'b10) begin errors++; $display("FAIL out_rd_resp got rv/err %b exp 10", {rv, er}); end
    checks++; if (rd !== 32'hA5A5_0F0F) begin errors++; $display("FAIL out_rd_data got %h exp a5a50f0f", rd); end
    idle(1);
    checks++; if ({rvalid, rdata} !== 33'h0) begin errors++; $display("FAIL out_rvalid_drop got %b/%h exp 0/0", rvalid, rdata); end
  endtask

  task automatic test_atomic;
    bus(1, 32'h00, 4'hF, 32'h0000_00F0, rv, rd, er);
    bus(1, 32'h0C, 4'hF, 32'h0000_000F, rv, rd, er);
    checks++; if (gpio_out !== 32'h0000_00FF) begin errors++; $display("FAIL set_pins got %h exp 000000ff", gpio_out); end
    bus(1, 32'h10, 4'hF, 32'h0000_0081, rv, rd, er);
    bus(0, 32'h00, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0000_007E) begin errors++; $display("FAIL clr_read got %h exp 0000007e", rd); end
    bus(1, 32'h00, 4'b0010, 32'hFFFF_FFFF, rv, rd, er);
    bus(0, 32'h00, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0000_FF7E) begin errors++; $display("FAIL be_write got %h exp 0000ff7e", rd); end
    bus(1, 32'h0C, 4'b0001, 32'hFFFF_0000, rv, rd, er);
    checks++; if (gpio_out !== 32'h0000_FF7E) begin errors++; $display("FAIL set_be_off got %h exp 0000ff7e", gpio_out); end
    bus(0, 32'h0C, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL set_read got %h exp 0", rd); end
  endtask

  task automatic test_input_sync;
    gpio_in = 32'h0;
    idle(6 + DB);
    gpio_in = 32'h0000_0003;
    idle(1 + DB);
    bus(0, 32'h08, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sync_early got %h exp 0", rd); end
    bus(0, 32'h08, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL sync_ontime got %h exp 3", rd); end
  endtask

  task automatic test_edge_intr;
    gpio_in = 32'h0000_0002;
    idle(6 + DB);
    bus(1, 32'h14, 4'hF, 32'h1, rv, rd, er);
    bus(1, 32'h18, 4'hF, 32'h2, rv, rd, er);
    bus(0, 32'h1C, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL intr_masked got %h exp 0", rd); end
    gpio_in = 32'h0000_0001;
    idle(2 + DB);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL intr_early got %b exp 0", intr); end
    idle(1);
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL intr_ontime got %b exp 1", intr); end
    bus(0, 32'h1C, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL intr_state got %h exp 3", rd); end
    bus(1, 32'h1C, 4'hF, 32'h1, rv, rd, er);
    bus(0, 32'h1C, 4'hF, 0, rv, rd, er);
    checks++; if ({intr, rd} !== {1'b1, 32'h2}) begin errors++; $display("FAIL w1c_bit0 got %b/%h exp 1/2", intr, rd); end
    bus(1, 32'h1C, 4'hF, 32'h2, rv, rd, er);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL w1c_bit1 got %b exp 0", intr); end
  endtask

  task automatic test_w1c_collision;
    gpio_in = 32'h0;
    idle(6 + DB);
    bus(0, 32'h1C, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL coll_pre got %h exp 0", rd); end
    gpio_in = 32'h0000_0001;
    idle(2 + DB);
    bus(1, 32'h1C, 4'hF, 32'h1, rv, rd, er);
    bus(0, 32'h1C, 4'hF, 0, rv, rd, er);
    checks++; if ({intr, rd} !== {1'b1, 32'h1}) begin errors++; $display("FAIL coll_set_wins got %b/%h exp 1/1", intr, rd); end
  endtask

  task automatic test_errors;
    bus(1, 32'h08, 4'hF, 32'hFFFF_FFFF, rv, rd, er);
    checks++; if ({rv, er} !== 2'b11) begin errors++; $display("FAIL err_wr_datain got rv/err %b exp 11", {rv, er}); end
    bus(0, 32'h08, 4'hF, 0, rv, rd, er);
    checks++; if ({er, rd} !== {1'b0, 32'h1}) begin errors++; $display("FAIL err_datain_kept got %b/%h exp 0/1", er, rd); end
    bus(0, 32'h02, 4'hF, 0, rv, rd, er);
    checks++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_misalign_rd got %b%b/%h exp 11/0", rv, er, rd); end
    bus(1, 32'h01, 4'hF, 32'h0, rv, rd, er);
    checks++; if ({er, gpio_out} !== {1'b1, 32'h0000_FF7E}) begin errors++; $display("FAIL err_misalign_wr got %b/%h exp 1/0000ff7e", er, gpio_out); end
  endtask

  task automatic test_back_to_back;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h00;
    @(posedge clk); #1; addr = 32'h04;
    checks++; if ({rvalid, rdata} !== {1'b1, 32'h0000_FF7E}) begin errors++; $display("FAIL b2b_0 got %b/%h exp 1/0000ff7e", rvalid, rdata); end
    @(posedge clk); #1; addr = 32'h14;
    checks++; if ({rvalid, rdata} !== {1'b1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL b2b_1 got %b/%h exp 1/ffffffff", rvalid, rdata); end
    @(posedge clk); #1; req = 1'b0;
    checks++; if ({rvalid, rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL b2b_2 got %b/%h exp 1/1", rvalid, rdata); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", rvalid); end
  endtask

  task automatic test_reset_mid;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h1C;
    @(posedge clk); #1; req = 1'b0;
    checks++; if ({rvalid, intr} !== 2'b11) begin errors++; $display("FAIL mid_pre got %b exp 11", {rvalid, intr}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rvalid, intr} !== 2'b00) begin errors++; $display("FAIL mid_flags got %b exp 00", {rvalid, intr}); end
    checks++; if ({gpio_out, gpio_oe} !== 64'h0) begin errors++; $display("FAIL mid_pins got %h/%h exp 0/0", gpio_out, gpio_oe); end
    @(posedge clk); #1; rst_n = 1'b1;
    gpio_in = 32'h0;
    bus(0, 32'h14, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rise_en got %h exp 0", rd); end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce;
    gpio_in = 32'h0;
    idle(40);
    gpio_in = 32'h1;
    idle(10);
    gpio_in = 32'h0;
    idle(40);
    bus(0, 32'h08, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL deb_glitch got %h exp 0", rd); end
    gpio_in = 32'h1;
    idle(20);
    bus(0, 32'h08, 4'hF, 0, rv, rd, er);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL deb_pulse got %h exp 1", rd); end
  endtask
`endif

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_output();
    test_atomic();
    test_input_sync();
    test_edge_intr();
    test_w1c_collision();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
